// File: rtl/lab61_soc_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv
// On-chip debug memory: 256x32 RAM shared by JTAG debug commands and a CPU Avalon-MM slave port.
// Define LAB61_SOC_OCIMEM_AUTOINC_EN to auto-increment MonAReg after every JTAG read/write.
module lab61_soc_nios2_gen2_0_cpu_debug_ocimem_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [37:0] jdo,
   input  logic        take_action_ocimem_a,
   input  logic        take_action_ocimem_b,
   input  logic        take_no_action_ocimem_a,
   input  logic [7:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   input  logic        debugaccess,
   output logic [31:0] readdata,
   output logic        waitrequest,
   output logic [31:0] MonDReg,
   output logic        monitor_ready,
   output logic        monitor_error
);

   typedef enum logic [2:0] {IDLE, JRD, JWR, CRD, CWR} state_t;

   state_t      state, state_nxt;
   logic [31:0] mem [0:255];
   logic [31:0] ram_q;
   logic [7:0]  mon_a_reg;
   logic        pending, pending_wr;
   logic        jdone, jdone_rd;

   logic        cmd_rd, cmd_wr, cmd, jtag_busy, accept, overrun;
   logic        jtag_go, jtag_go_wr, cpu_done;
   logic [7:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_be;
   logic        ram_we, ram_re;
   logic        jdo_unused;

   assign jdo_unused = ^{jdo[37:36], jdo[2:0]};

   assign cmd_rd    = take_no_action_ocimem_a | (take_action_ocimem_a & jdo[35] & jdo[34]);
   assign cmd_wr    = take_action_ocimem_b;
   assign cmd       = cmd_rd | cmd_wr;
   // An op is busy from acceptance until its completion edge (jdone), so MonDReg never has two writers.
   assign jtag_busy = pending | jdone | (state == JRD) | (state == JWR);
   assign accept    = cmd & ~jtag_busy;
   assign overrun   = cmd & jtag_busy;
   assign jtag_go    = pending | accept;
   assign jtag_go_wr = pending ? pending_wr : cmd_wr;

   assign cpu_done    = (state == CRD) || (state == CWR);
   assign waitrequest = (read | write) & ~cpu_done;
   assign readdata    = ram_q;

   always_comb begin
      state_nxt = IDLE;
      ram_addr  = mon_a_reg;
      ram_wdata = MonDReg;
      ram_be    = '1;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      case (state)
         IDLE: begin
            if (jtag_go) begin
               state_nxt = jtag_go_wr ? JWR : JRD;
            end else if (write) begin
               state_nxt = CWR;
               ram_addr  = address;
               ram_wdata = writedata;
               ram_be    = byteenable;
               ram_we    = debugaccess & reset_n;
            end else if (read) begin
               state_nxt = CRD;
               ram_addr  = address;
               ram_re    = 1'b1;
            end
         end
         JRD:     ram_re = 1'b1;
         JWR:     ram_we = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         pending       <= 1'b0;
         pending_wr    <= 1'b0;
         jdone         <= 1'b0;
         jdone_rd      <= 1'b0;
         mon_a_reg     <= '0;
         MonDReg       <= '0;
         monitor_ready <= 1'b0;
         monitor_error <= 1'b0;
      end else begin
         state    <= state_nxt;
         jdone    <= (state == JRD) || (state == JWR);
         jdone_rd <= (state == JRD);

         // Commands accepted while a CPU access occupies the FSM wait in the pending flag.
         if (state == IDLE) begin
            pending <= 1'b0;
         end else if (accept) begin
            pending    <= 1'b1;
            pending_wr <= cmd_wr;
         end

         if (accept && cmd_wr)
            MonDReg <= jdo[34:3];
         else if (jdone_rd)
            MonDReg <= ram_q;

         if (take_action_ocimem_a && jdo[35])
            mon_a_reg <= jdo[33:26];
`ifdef LAB61_SOC_OCIMEM_AUTOINC_EN
         else if (jdone)
            mon_a_reg <= mon_a_reg + 8'd1;
`endif

         if (jdone)
            monitor_ready <= 1'b1;
         else if (take_action_ocimem_a && jdo[24])
            monitor_ready <= 1'b0;

         if (overrun)
            monitor_error <= 1'b1;
         else if (take_action_ocimem_a && jdo[25])
            monitor_error <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ram_q <= '0;
      else if (ram_re)
         ram_q <= mem[ram_addr];
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (ram_be[i])
               mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_lab61_soc_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv
// Scoreboard bench for the OCI debug memory controller: JTAG/CPU access, contention, overrun, reset.
module tb_lab61_soc_nios2_gen2_0_cpu_debug_ocimem_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [37:0] jdo;
   logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
   logic [7:0]  address;
   logic        read, write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        debugaccess;
   logic [31:0] readdata;
   logic        waitrequest;
   logic [31:0] MonDReg;
   logic        monitor_ready, monitor_error;

   always #5 clk = ~clk;

   lab61_soc_nios2_gen2_0_cpu_debug_ocimem_ctrl dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .address                 (address),
      .read                    (read),
      .write                   (write),
      .writedata               (writedata),
      .byteenable              (byteenable),
      .debugaccess             (debugaccess),
      .readdata                (readdata),
      .waitrequest             (waitrequest),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error)
   );

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t    sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] model_mem [0:255];
   logic [7:0]  marg;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] exp);
      sb_item_t it;
      it.tag = tag;
      it.exp = exp;
      sb.push_back(it);
   endtask

   task automatic sb_pop(input logic [31:0] got);
      sb_item_t it;
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
         it = sb.pop_front();
         check(it.tag, got, it.exp);
      end
   endtask

   task automatic marg_step();
`ifdef LAB61_SOC_OCIMEM_AUTOINC_EN
      marg = marg + 8'd1;
`endif
   endtask

   task automatic pulse_a(input logic ld, input logic rd, input logic clr_err, input logic clr_rdy,
                          input logic [7:0] addr);
      logic [37:0] j;
      j = '0;
      j[35] = ld;
      j[34] = rd;
      j[33:26] = addr;
      j[25] = clr_err;
      j[24] = clr_rdy;
      jdo = j;
      take_action_ocimem_a = 1'b1;
      @(negedge clk);
      take_action_ocimem_a = 1'b0;
      if (ld) marg = addr;
   endtask

   task automatic jtag_write(input logic [7:0] addr, input logic [31:0] data);
      pulse_a(1'b1, 1'b0, 1'b0, 1'b0, addr);
      jdo = {3'b000, data, 3'b000};
      take_action_ocimem_b = 1'b1;
      @(negedge clk);
      take_action_ocimem_b = 1'b0;
      model_mem[marg] = data;
      @(negedge clk);
      @(negedge clk);
      check("jwr_ready", {31'd0, monitor_ready}, 32'd1);
      marg_step();
   endtask

   task automatic jtag_read(input logic [7:0] addr);
      sb_push("jrd_data", model_mem[addr]);
      pulse_a(1'b1, 1'b1, 1'b0, 1'b1, addr);
      check("jrd_ready_n1", {31'd0, monitor_ready}, 32'd0);
      @(negedge clk);
      check("jrd_ready_n2", {31'd0, monitor_ready}, 32'd0);
      @(negedge clk);
      sb_pop(MonDReg);
      check("jrd_ready", {31'd0, monitor_ready}, 32'd1);
      marg_step();
   endtask

   task automatic jtag_read_cur();
      sb_push("jrd_cur_data", model_mem[marg]);
      take_no_action_ocimem_a = 1'b1;
      @(negedge clk);
      take_no_action_ocimem_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      sb_pop(MonDReg);
      marg_step();
   endtask

   task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be,
                            input logic dbg);
      int cnt;
      address = addr; writedata = data; byteenable = be; debugaccess = dbg; write = 1'b1;
      #1;
      cnt = 0;
      while (waitrequest && cnt < 20) begin
         cnt++;
         @(negedge clk);
         #1;
      end
      write = 1'b0;
      check("cpu_wr_wait", cnt, 32'd1);
      if (dbg) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) model_mem[addr][8*i +: 8] = data[8*i +: 8];
      end
      @(negedge clk);
   endtask

   task automatic cpu_read(input logic [7:0] addr);
      int cnt;
      sb_push("cpu_rd_data", model_mem[addr]);
      address = addr; debugaccess = 1'b0; read = 1'b1;
      #1;
      cnt = 0;
      while (waitrequest && cnt < 20) begin
         cnt++;
         @(negedge clk);
         #1;
      end
      sb_pop(readdata);
      read = 1'b0;
      check("cpu_rd_wait", cnt, 32'd1);
      @(negedge clk);
   endtask

   initial begin
      int cnt;
      reset_n = 1'b0;
      jdo = '0;
      take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
      address = '0; read = 1'b0; write = 1'b0; writedata = '0; byteenable = '0; debugaccess = 1'b0;
      marg = '0;
      repeat (2) @(negedge clk);
      check("rst_mondreg", MonDReg, 32'd0);
      check("rst_ready", {31'd0, monitor_ready}, 32'd0);
      check("rst_error", {31'd0, monitor_error}, 32'd0);
      check("rst_readdata", readdata, 32'd0);
      check("rst_waitreq", {31'd0, waitrequest}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      jtag_write(8'h10, 32'hDEADBEEF);
      jtag_read(8'h10);

      cpu_write(8'h10, 32'h000000AA, 4'b0001, 1'b1);
      cpu_read(8'h10);
      cpu_write(8'h10, 32'h55555555, 4'b1111, 1'b0);
      cpu_read(8'h10);

      cpu_write(8'h00, 32'h11112222, 4'b1111, 1'b1);
      cpu_write(8'hFF, 32'h33334444, 4'b1111, 1'b1);
      cpu_write(8'h20, 32'h12345678, 4'b1111, 1'b1);
      cpu_write(8'h30, 32'h0BADF00D, 4'b1111, 1'b1);
      cpu_write(8'h30, 32'hA5A5C3C3, 4'b1100, 1'b1);
      cpu_read(8'h00);
      cpu_read(8'hFF);
      cpu_read(8'h30);
      jtag_read(8'hFF);

      // Contention: JTAG read of 8'hFF and CPU read of 8'h30 requested together
      pulse_a(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
      sb_push("cont_jtag", model_mem[marg]);
      sb_push("cont_cpu", model_mem[8'h30]);
      address = 8'h30; read = 1'b1; take_no_action_ocimem_a = 1'b1;
      #1;
      cnt = 0;
      while (waitrequest && cnt < 20) begin
         cnt++;
         @(negedge clk);
         take_no_action_ocimem_a = 1'b0;
         #1;
      end
      read = 1'b0;
      sb_pop(MonDReg);
      sb_pop(readdata);
      check("cont_wait", cnt, 32'd3);
      marg_step();
      @(negedge clk);

      // Overrun: commands in two consecutive cycles, second dropped
      pulse_a(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      sb_push("ovr_data", model_mem[marg]);
      take_no_action_ocimem_a = 1'b1;
      @(negedge clk);
      @(negedge clk);
      take_no_action_ocimem_a = 1'b0;
      check("ovr_error", {31'd0, monitor_error}, 32'd1);
      @(negedge clk);
      sb_pop(MonDReg);
      marg_step();
      @(negedge clk);
      check("ovr_error_held", {31'd0, monitor_error}, 32'd1);
      pulse_a(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      check("ovr_error_clr", {31'd0, monitor_error}, 32'd0);

      // MonAReg at the top of the range
      pulse_a(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
      jtag_read_cur();
      jtag_read_cur();

      // Reset while the JTAG write to 8'h20 is in its write cycle
      pulse_a(1'b1, 1'b0, 1'b0, 1'b0, 8'h20);
      jdo = {3'b000, 32'hCAFEF00D, 3'b000};
      take_action_ocimem_b = 1'b1;
      @(negedge clk);
      take_action_ocimem_b = 1'b0;
      #1;
      reset_n = 1'b0;
      #1;
      check("mrst_mondreg", MonDReg, 32'd0);
      check("mrst_ready", {31'd0, monitor_ready}, 32'd0);
      check("mrst_error", {31'd0, monitor_error}, 32'd0);
      check("mrst_readdata", readdata, 32'd0);
      check("mrst_waitreq", {31'd0, waitrequest}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      marg = '0;
      @(negedge clk);
      check("post_rst_waitreq", {31'd0, waitrequest}, 32'd0);
      cpu_read(8'h20);
      jtag_read_cur();

      check("sb_drained", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lab61_soc_nios2_gen2_0_cpu_debug_ocimem_ctrl.md
LAB61_SOC_NIOS2_GEN2_0_CPU_DEBUG_OCIMEM_CTRL -- requirements
Module: lab61_soc_nios2_gen2_0_cpu_debug_ocimem_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named clk and reset_n as in the codebase.
REQ-002 SHALL provide: clk  in  1  system clock.
REQ-003 SHALL provide: reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL provide: jdo  in  38  debug data word from the sysclk debug stage.
REQ-005 SHALL provide: take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a  in  1 each  single-cycle JTAG command pulses.
REQ-006 SHALL provide: address  in  8, read  in  1, write  in  1, writedata  in  32, byteenable  in  4, debugaccess  in  1  CPU Avalon-MM slave port.
REQ-007 SHALL provide: readdata  out  32, waitrequest  out  1  Avalon-MM slave responses.
REQ-008 SHALL provide: MonDReg  out  32, monitor_ready  out  1, monitor_error  out  1  status back to the debug TCK stage.

Function
REQ-009 SHALL hold a 256x32 single-port RAM with 1-cycle registered read latency, plus an 8-bit address register MonAReg.
REQ-010 On take_action_ocimem_a with jdo[35]=1, SHALL load MonAReg <= jdo[33:26]; if jdo[34]=1, SHALL also queue a JTAG read at the new address.
REQ-011 On take_action_ocimem_a, jdo[25]=1 SHALL clear monitor_error and jdo[24]=1 SHALL clear monitor_ready, in the same cycle as the pulse.
REQ-012 On take_no_action_ocimem_a, SHALL queue a JTAG read at MonAReg.
REQ-013 On take_action_ocimem_b, SHALL load MonDReg <= jdo[34:3] and queue a JTAG write of MonDReg to MonAReg, with all byte lanes enabled.
REQ-014 A single pending flag SHALL hold a queued JTAG operation; if a new command arrives while one is pending or active, the new command SHALL be dropped and monitor_error SHALL be set to 1.
REQ-015 FSM states SHALL be IDLE, JRD, JWR, CRD, CWR.
- IDLE -> JRD/JWR when a JTAG operation is pending.
- Otherwise IDLE -> CRD/CWR on read/write.
- Every other state returns to IDLE after 1 cycle.
REQ-016 When a JTAG operation and a CPU access are requested in the same IDLE cycle, the JTAG operation SHALL win; the CPU access SHALL stall.
REQ-017 JTAG read timing, from an idle FSM: pulse at edge N, RAM read issued at N+1, MonDReg captured and monitor_ready=1 at N+2.
REQ-018 JTAG write timing, from an idle FSM: the RAM write SHALL occur at N+1 and monitor_ready=1 at N+2.
REQ-019 waitrequest SHALL be combinational: (read|write) & ~cpu_done. cpu_done SHALL be high for exactly the cycle after a CRD/CWR state. readdata SHALL be valid in that same cycle.
REQ-020 An uncontended CPU access SHALL complete in 2 cycles; each stall cycle caused by a JTAG operation SHALL add 2 cycles.
REQ-021 CPU writes SHALL honour byteenable. A write with debugaccess=0 SHALL complete normally but leave the RAM unmodified. Reads SHALL ignore debugaccess.
REQ-022 MonAReg SHALL wrap from 8'hFF to 8'h00.

Reset
REQ-023 Asserting reset_n low SHALL immediately force the following, including mid-operation:
- MonAReg=0, MonDReg=0, monitor_ready=0, monitor_error=0, readdata=0.
- pending flag cleared, FSM=IDLE.
REQ-024 With no read or write asserted, waitrequest SHALL be 0 during and after reset. RAM contents SHALL NOT be reset. An operation in progress at reset SHALL be abandoned, and its RAM write SHALL NOT occur.

Configuration
REQ-025 Macro LAB61_SOC_OCIMEM_AUTOINC_EN defined: MonAReg SHALL increment by 1, with wrap, on completion of every JTAG read or write.
REQ-026 LAB61_SOC_OCIMEM_AUTOINC_EN undefined: MonAReg SHALL change only via REQ-010; all other behaviour SHALL be identical.

Verification
REQ-027 JTAG write then read:
- Stimulus: ocimem_a with jdo[35]=1, jdo[33:26]=8'h10; ocimem_b with jdo[34:3]=32'hDEADBEEF; ocimem_a with jdo[35:34]=2'b11, addr 8'h10.
- Response: MonDReg=32'hDEADBEEF and monitor_ready=1 two cycles after the last pulse.
REQ-028 CPU byte write:
- Stimulus: write to address 8'h10 with byteenable=4'b0001, writedata=32'h000000AA, debugaccess=1; then CPU read of 8'h10.
- Response: readdata=32'hDEADBEAA; waitrequest high for exactly 1 cycle per access.
REQ-029 Contention: same-cycle take_no_action_ocimem_a and CPU read -> JTAG read completes first; CPU waitrequest high for 3 cycles.
REQ-030 Overrun: two command pulses 1 cycle apart -> second dropped, monitor_error=1; ocimem_a with jdo[25]=1 -> monitor_error=0.
REQ-031 Reset mid-write: reset_n low during JWR -> all outputs zero, RAM word unchanged when read back after reset.
REQ-032 Autoinc, with the macro defined: MonAReg=8'hFF, then two take_no_action_ocimem_a pulses -> reads return RAM[8'hFF], then RAM[8'h00].
